// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters, trained from EX.
// Also carries the fetch-time predicted-taken flag to EX and flags mispredictions there.
module branch_target_buffer #(
    parameter int unsigned IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    output logic [31:0] PredictedPC,
    output logic        PredictedF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic [31:0] PCE,
    input  logic        BrInstE,
    input  logic        BranchE,
    input  logic [31:0] BranchTarget,
    output logic        PredictedE,
    output logic        MispredictE,
    output logic [31:0] FallThroughE
);

    localparam int unsigned Entries = 1 << IDX_BITS;
    localparam int unsigned TagBits = 32 - IDX_BITS - 2;

    logic               valid_q  [Entries];
    logic               valid_d  [Entries];
    logic [TagBits-1:0] tag_q    [Entries];
    logic [TagBits-1:0] tag_d    [Entries];
    logic [31:0]        target_q [Entries];
    logic [31:0]        target_d [Entries];
    logic [1:0]         cnt_q    [Entries];
    logic [1:0]         cnt_d    [Entries];

    logic pred_dec_q, pred_dec_d;
    logic pred_ex_q, pred_ex_d;

    logic [IDX_BITS-1:0] idx_f, idx_e;
    logic [TagBits-1:0]  tag_f, tag_e;
    logic                hit_f, hit_e;

    // Byte offset bits never participate in index or tag.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

    assign idx_f = PCF[IDX_BITS+1:2];
    assign tag_f = PCF[31:IDX_BITS+2];
    assign idx_e = PCE[IDX_BITS+1:2];
    assign tag_e = PCE[31:IDX_BITS+2];

    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    assign PredictedF  = hit_f && cnt_q[idx_f][1];
    assign PredictedPC = PredictedF ? target_q[idx_f] : 32'd0;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (BrInstE && !StallE) begin
            if (hit_e) begin
                if (BranchE) begin
                    if (cnt_q[idx_e] != 2'b11) begin
                        cnt_d[idx_e] = cnt_q[idx_e] + 2'b01;
                    end
                    target_d[idx_e] = BranchTarget;
                end else if (cnt_q[idx_e] != 2'b00) begin
                    cnt_d[idx_e] = cnt_q[idx_e] - 2'b01;
                end
            end else if (BranchE) begin
                // Not-taken misses never allocate; taken misses evict the occupant.
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = tag_e;
                target_d[idx_e] = BranchTarget;
                cnt_d[idx_e]    = 2'b10;
            end
        end
    end

    always_comb begin
        pred_dec_d = FlushD ? 1'b0 : (StallD ? pred_dec_q : PredictedF);
        pred_ex_d  = FlushE ? 1'b0 : (StallE ? pred_ex_q : pred_dec_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Entries); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                cnt_q[i]    <= 2'b01;
            end
            pred_dec_q <= 1'b0;
            pred_ex_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            pred_dec_q <= pred_dec_d;
            pred_ex_q  <= pred_ex_d;
        end
    end

    assign PredictedE   = pred_ex_q;
    // A predicted-taken flag on anything but a taken branch (including non-branches) mispredicts.
    assign MispredictE  = pred_ex_q && !(BrInstE && BranchE);
    assign FallThroughE = PCE + 32'd4;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Table-driven bench for branch_target_buffer with an expectation queue checked at negedge,
// plus a hand-written asynchronous reset sequence.
module tb_branch_target_buffer;

    logic        clk;
    logic        rst_n;
    logic [31:0] PCF;
    logic [31:0] PredictedPC;
    logic        PredictedF;
    logic        StallD, FlushD, StallE, FlushE;
    logic [31:0] PCE;
    logic        BrInstE, BranchE;
    logic [31:0] BranchTarget;
    logic        PredictedE, MispredictE;
    logic [31:0] FallThroughE;

    branch_target_buffer #(.IDX_BITS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PCF          (PCF),
        .PredictedPC  (PredictedPC),
        .PredictedF   (PredictedF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .PCE          (PCE),
        .BrInstE      (BrInstE),
        .BranchE      (BranchE),
        .BranchTarget (BranchTarget),
        .PredictedE   (PredictedE),
        .MispredictE  (MispredictE),
        .FallThroughE (FallThroughE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pcf;
        logic [31:0] pce;
        logic        br;
        logic        tk;
        logic [31:0] tgt;
        logic        fd;
        logic        sd;
        logic        fe;
        logic        se;
        logic        pf;
        logic [31:0] ppc;
        logic        pe;
        logic        mis;
        logic [31:0] ft;
    } vec_t;

    typedef struct {
        string       name;
        logic        pf;
        logic [31:0] ppc;
        logic        pe;
        logic        mis;
        logic [31:0] ft;
    } exp_t;

    exp_t sb_q[$];
    vec_t vq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(logic [31:0] pcf, logic [31:0] pce, logic br, logic tk,
                                logic [31:0] tgt, logic fd, logic sd, logic fe, logic se,
                                logic pf, logic [31:0] ppc, logic pe, logic mis,
                                logic [31:0] ft);
        vec_t v;
        v.pcf = pcf; v.pce = pce; v.br = br; v.tk = tk; v.tgt = tgt;
        v.fd = fd; v.sd = sd; v.fe = fe; v.se = se;
        v.pf = pf; v.ppc = ppc; v.pe = pe; v.mis = mis; v.ft = ft;
        return v;
    endfunction

    task automatic cmp(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s %s: got %0h expected %0h", name, field, act, exp);
    endtask

    task automatic drain();
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cmp(e.name, "PredictedF",   {31'd0, PredictedF},  {31'd0, e.pf});
            cmp(e.name, "PredictedPC",  PredictedPC,          e.ppc);
            cmp(e.name, "PredictedE",   {31'd0, PredictedE},  {31'd0, e.pe});
            cmp(e.name, "MispredictE",  {31'd0, MispredictE}, {31'd0, e.mis});
            cmp(e.name, "FallThroughE", FallThroughE,         e.ft);
        end
    endtask

    task automatic push(input string name, input logic pf, input logic [31:0] ppc,
                        input logic pe, input logic mis, input logic [31:0] ft);
        exp_t e;
        e.name = name; e.pf = pf; e.ppc = ppc; e.pe = pe; e.mis = mis; e.ft = ft;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) drain();

    initial begin
        // Training, saturation, aliasing, same-cycle update, wrap, then flag pipeline cases.
        vq.push_back(mk(32'h100, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h4));
        vq.push_back(mk(32'h304, 32'h100, 1, 1, 32'h200, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h104));
        vq.push_back(mk(32'h100, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 1, 32'h200, 0, 0, 32'h4));
        vq.push_back(mk(32'h304, 32'h100, 1, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h104));
        vq.push_back(mk(32'h100, 32'h100, 1, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   1, 1, 32'h104));
        for (int k = 0; k < 3; k++)
            vq.push_back(mk(32'h100, 32'h100, 1, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h104));
        vq.push_back(mk(32'h100, 32'h100, 1, 1, 32'h200, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h104));
        vq.push_back(mk(32'h100, 32'h100, 1, 1, 32'h200, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h104));
        vq.push_back(mk(32'h100, 32'h100, 1, 1, 32'h200, 0, 0, 0, 0, 1, 32'h200, 0, 0, 32'h104));
        vq.push_back(mk(32'h100, 32'h100, 1, 1, 32'h200, 0, 0, 0, 0, 1, 32'h200, 0, 0, 32'h104));
        vq.push_back(mk(32'h100, 32'h100, 1, 0, 32'h0,   0, 0, 0, 0, 1, 32'h200, 1, 1, 32'h104));
        vq.push_back(mk(32'h100, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 1, 32'h200, 1, 1, 32'h4));
        vq.push_back(mk(32'h304, 32'h140, 1, 1, 32'h400, 0, 0, 0, 0, 0, 32'h0,   1, 0, 32'h144));
        vq.push_back(mk(32'h100, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   1, 1, 32'h4));
        vq.push_back(mk(32'h140, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 1, 32'h400, 0, 0, 32'h4));
        vq.push_back(mk(32'h140, 32'h140, 1, 1, 32'h480, 0, 0, 0, 0, 1, 32'h400, 0, 0, 32'h144));
        vq.push_back(mk(32'h140, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 0, 0, 0, 1, 32'h480, 1, 1, 32'h0));
        vq.push_back(mk(32'h304, 32'h0,   0, 0, 32'h0,   1, 0, 0, 0, 0, 32'h0,   1, 1, 32'h4));
        vq.push_back(mk(32'h140, 32'h0,   0, 0, 32'h0,   1, 0, 0, 0, 1, 32'h480, 1, 1, 32'h4));
        vq.push_back(mk(32'h304, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h4));
        vq.push_back(mk(32'h304, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h4));
        vq.push_back(mk(32'h140, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 1, 32'h480, 0, 0, 32'h4));
        vq.push_back(mk(32'h140, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 1, 32'h480, 0, 0, 32'h4));
        vq.push_back(mk(32'h304, 32'h0,   0, 0, 32'h0,   0, 0, 1, 1, 0, 32'h0,   1, 1, 32'h4));
        vq.push_back(mk(32'h304, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h4));
        vq.push_back(mk(32'h140, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 1, 32'h480, 0, 0, 32'h4));
        vq.push_back(mk(32'h304, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h4));
        for (int k = 0; k < 3; k++)
            vq.push_back(mk(32'h304, 32'h140, 1, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 1, 1, 32'h144));
        vq.push_back(mk(32'h140, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 1, 32'h480, 1, 1, 32'h4));
        vq.push_back(mk(32'h304, 32'h0,   0, 0, 32'h0,   0, 1, 0, 0, 0, 32'h0,   0, 0, 32'h4));
        vq.push_back(mk(32'h304, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   1, 1, 32'h4));
        vq.push_back(mk(32'h304, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   1, 1, 32'h4));
        vq.push_back(mk(32'h304, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h4));
        vq.push_back(mk(32'h140, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 1, 32'h480, 0, 0, 32'h4));
        vq.push_back(mk(32'h140, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 1, 32'h480, 0, 0, 32'h4));

        rst_n = 1'b0;
        PCF = 32'h100; PCE = 32'h0; BrInstE = 1'b0; BranchE = 1'b0; BranchTarget = 32'h0;
        StallD = 1'b0; FlushD = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        #3;
        push("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h4);
        drain();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            PCF = vq[i].pcf; PCE = vq[i].pce; BrInstE = vq[i].br; BranchE = vq[i].tk;
            BranchTarget = vq[i].tgt;
            FlushD = vq[i].fd; StallD = vq[i].sd; FlushE = vq[i].fe; StallE = vq[i].se;
            push($sformatf("row%0d", i), vq[i].pf, vq[i].ppc, vq[i].pe, vq[i].mis, vq[i].ft);
        end

        // Asynchronous reset between edges, with a taken branch pending in EX.
        @(posedge clk);
        #1;
        PCF = 32'h140; PCE = 32'h0; BrInstE = 1'b0; BranchE = 1'b0;
        FlushD = 1'b0; StallD = 1'b0; FlushE = 1'b0; StallE = 1'b0;
        push("pre_reset", 1'b1, 32'h480, 1'b1, 1'b1, 32'h4);
        #1 drain();
        PCE = 32'h300; BrInstE = 1'b1; BranchE = 1'b1; BranchTarget = 32'h500;
        #1 rst_n = 1'b0;
        #1;
        push("async_reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h304);
        drain();
        @(posedge clk);
        #1 BrInstE = 1'b0; BranchE = 1'b0; PCE = 32'h0;
        #1 rst_n = 1'b1;
        #1;
        push("post_reset_140", 1'b0, 32'h0, 1'b0, 1'b0, 32'h4);
        drain();
        PCF = 32'h100;
        #1;
        push("post_reset_100", 1'b0, 32'h0, 1'b0, 1'b0, 32'h4);
        drain();
        PCF = 32'h300;
        #1;
        push("aborted_write", 1'b0, 32'h0, 1'b0, 1'b0, 32'h4);
        drain();

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: got %0d pending expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Fetch-stage branch predictor that produces `PredictedPC`, `PredictedF` and `PredictedE` for the next-PC selection logic.
- Direct-mapped BTB with a 2-bit saturating direction counter per entry. Looked up combinationally on `PCF`.
- Trained from EX-stage branch resolution.
- Carries the fetch-time prediction flag down the F→D→E pipeline and flags mispredictions in EX.

Parameters:
- `IDX_BITS`, 4, log2 of entry count (16 entries); index = `PC[IDX_BITS+1:2]`, tag = `PC[31:IDX_BITS+2]`.

Ports:
- `clk`  in  1  core clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `PCF`  in  32  fetch-stage PC
- `PredictedPC`  out  32  predicted target for `PCF`
- `PredictedF`  out  1  `PCF` predicted taken this cycle
- `StallD`  in  1  hold D-stage prediction flag
- `FlushD`  in  1  clear D-stage prediction flag
- `StallE`  in  1  hold E-stage prediction flag
- `FlushE`  in  1  clear E-stage prediction flag
- `PCE`  in  32  EX-stage instruction PC
- `BrInstE`  in  1  EX-stage instruction is a conditional branch
- `BranchE`  in  1  EX-stage branch resolved taken
- `BranchTarget`  in  32  EX-stage computed branch target
- `PredictedE`  out  1  EX-stage instruction was fetched as predicted-taken
- `MispredictE`  out  1  predicted taken but not actually taken in EX
- `FallThroughE`  out  32  `PCE+4`; recovery PC when `MispredictE`

Behaviour:
- Storage per entry: `valid` (1), `tag` (32-`IDX_BITS`-2), `target` (32), `cnt` (2).
- Reset (async, `rst_n`=0):
  - All `valid`=0 and all `cnt`=2'b01.
  - D/E prediction flags = 0.
  - Tag and target contents are don't-care.
  - Outputs during reset: `PredictedF`=0, `PredictedE`=0, `MispredictE`=0, `PredictedPC`=0.
  - Reset asserted mid-training aborts any pending write.
- Lookup (combinational, zero latency):
  - hit = `valid[idx(PCF)]` & (`tag[idx(PCF)]` == `tag(PCF)`).
  - `PredictedF` = hit & `cnt[1]`.
  - `PredictedPC` = `target` when `PredictedF`, else 0.
- Training (rising edge, when `BrInstE`=1 & `StallE`=0), indexed by `PCE`:
  - Hit and `BranchE`=1: `cnt` increments, saturating at 2'b11; `target` ← `BranchTarget`.
  - Hit and `BranchE`=0: `cnt` decrements, saturating at 2'b00; `target` unchanged; entry stays valid.
  - Miss and `BranchE`=1: allocate (overwrite any occupant): `valid`=1, `tag`=`tag(PCE)`, `target`=`BranchTarget`, `cnt`=2'b10.
  - Miss and `BranchE`=0: no change (not-taken branches never allocate).
- Same-cycle lookup and training on the same index: lookup returns pre-edge contents; the update is visible from the next cycle.
- Prediction-flag pipeline:
  - `predD` ← `FlushD` ? 0 : `StallD` ? `predD` : `PredictedF`.
  - `predE` ← `FlushE` ? 0 : `StallE` ? `predE` : `predD`.
  - Flush has priority over stall.
  - `PredictedE` = `predE`.
- Misprediction (combinational):
  - `MispredictE` = `predE` & ~(`BrInstE` & `BranchE`). This also covers a stale predicted-taken flag on a non-branch.
  - `FallThroughE` = `PCE` + 32'd4, wrapping modulo 2^32.
  - A taken branch with `predE`=0 is not flagged here; the normal `BranchE` redirect handles it.
- Width rules:
  - PC bits [1:0] are ignored for index and tag.
  - `cnt` arithmetic is 2-bit saturating, never wrapping.

Test Plan:
- Reset then `PCF`=0x100 → `PredictedF`=0; taken branch at `PCE`=0x100, `BranchTarget`=0x200 → next cycle `PCF`=0x100 gives `PredictedF`=1, `PredictedPC`=0x200 (`cnt`=10).
- Same branch resolved not-taken twice → `cnt` 10→01→00, `PredictedF`=0; three further not-taken keep `cnt`=00. Four taken → 01,10,11,11 (saturates), `PredictedF`=1 from the second.
- Aliasing: train 0x100 taken, then 0x140 taken (same idx, `IDX_BITS`=4) → 0x100 misses, 0x140 hits with its own target.
- Pipeline flag: `PredictedF`=1, no stalls → `PredictedE`=1 two edges later. If resolved `BranchE`=0 → `MispredictE`=1, `FallThroughE`=0x104. Same sequence with `FlushD` on the middle edge → `PredictedE`=0, `MispredictE`=0. `StallE` held 3 cycles → `PredictedE` held and no training occurs.
- Simultaneous: training write to idx of current `PCF` → `PredictedF` reflects old entry that cycle, new entry next cycle. `PCE`=0xFFFFFFFC → `FallThroughE`=0x0.
- `rst_n` pulsed low asynchronously mid-stream (between edges) → `PredictedF`, `PredictedE` and `MispredictE` go 0 immediately. After release, previously trained PCs miss.
